axis_frame_source: RTL and testbench
====================================

# axis_frame_source

AXI4-Stream master that reads a stored RGB frame from a synchronous single-port pixel memory and streams it into the haze-removal core's slave interface. Atmospheric light estimation consumes one full frame before transmission estimation can start, so the block replays the same frame `NUM_PASSES` times back to back. It marks each replay with start-of-frame and end-of-line sidebands. Memory read latency is hidden behind a 2-entry output buffer, so the block sustains 1 beat/cycle under full backpressure compliance.

## Interface
- `IMG_WIDTH`, 512, pixels per line (≥2)
- `IMG_HEIGHT`, 512, lines per frame (≥1)
- `ADDR_WIDTH`, 18, pixel-memory address width; must satisfy 2^ADDR_WIDTH ≥ IMG_WIDTH·IMG_HEIGHT
- `NUM_PASSES`, 2, frame replays per `start` (1..3)

Ports:
- `ACLK` in 1: single clock
- `ARESETn` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle request; sampled only in IDLE
- `busy` out 1: high from the cycle after `start` is accepted until `done`
- `done` out 1: one-cycle pulse after the final beat handshake
- `pass_idx` out 2: index of the pass currently being read (0-based)
- `mem_en` out 1: memory read enable
- `mem_addr` out ADDR_WIDTH: linear address, row·IMG_WIDTH+col
- `mem_rdata` in 24: {R,G,B}, valid exactly 1 cycle after `mem_en`
- `M_AXIS_TDATA` out 32: {8'd0, R, G, B}
- `M_AXIS_TVALID` out 1
- `M_AXIS_TLAST` out 1: last pixel of each line
- `M_AXIS_TUSER` out 1: first pixel of each pass
- `M_AXIS_TREADY` in 1

## Operation
- FSM states:
  - IDLE: `start`=1 → RUN; clears the address, column, row and pass counters.
  - RUN: issues reads. After the read of the last address of the last pass → DRAIN.
  - DRAIN: no reads; waits for the buffer and the in-flight read to empty. Buffer empty with no read in flight → DONE.
  - DONE: asserts `done` for 1 cycle → IDLE.
- Read issue in RUN: `mem_en`=1 when (buffer occupancy + in-flight reads − pops this cycle) < 2. In-flight count is at most 1.
- Address counter: increments on each issued read. After IMG_WIDTH·IMG_HEIGHT−1 it wraps to 0 and `pass_idx` increments.
- Each issued read carries two sideband bits into the buffer:
  - `last` = (col == IMG_WIDTH−1)
  - `first` = (address == 0)
- Buffer is a 2-entry FIFO of {first, last, rgb}. The head entry drives the AXIS outputs. A pop occurs on `TVALID && TREADY`.
- `TVALID` = buffer non-empty. `TVALID` never depends combinationally on `TREADY`.
- While `TVALID && !TREADY`: `TDATA`, `TLAST` and `TUSER` hold stable.
- `TDATA[31:24]` is always 0.
- `start` is ignored outside IDLE.
- `done` and `start` in the same cycle: `start` is ignored.

## Timing
- Reset values: all outputs 0, FSM in IDLE, buffer empty.
- Reset assertion: asynchronous. `TVALID` and `mem_en` drop immediately; in-flight data is discarded.
- Cycle numbering, with `start` sampled at edge 0:
  - cycle 1: `busy`=1, `mem_en`=1, `mem_addr`=0
  - edge 2: data captured; `TVALID`=1 in cycle 2
- With `TREADY` held high, one beat per cycle with no bubbles, including across line and pass boundaries.
- Total beats per `start` = IMG_WIDTH·IMG_HEIGHT·NUM_PASSES.
- `done` is high the cycle after the final handshake; `busy` falls in the same cycle.
- `TREADY` low for any duration: at most 2 buffered beats plus 0 reads in flight. No data is lost or duplicated.

## Test plan
- IMG_WIDTH=4, IMG_HEIGHT=2, NUM_PASSES=2, `TREADY`=1, memory word at address a = {a, ~a, a^8'h5A}:
  - 16 beats on consecutive cycles starting at cycle 2, `TDATA` = pattern for a = 0..7, 0..7
  - `TUSER` high on beats 0 and 8
  - `TLAST` high on beats 3, 7, 11, 15
  - `done` in cycle 18
- Same setup with `TREADY` random at 50%: identical beat sequence and sidebands; `TDATA`/`TLAST`/`TUSER` stable during every stall; `mem_en` never issues when 2 entries are buffered.
- `TREADY` low from cycle 1 to cycle 10: exactly 2 beats buffered; `mem_en` low from cycle 3; after release, beats resume back to back and the total is still 16.
- `start` pulsed while `busy`: no effect; beat count stays 16; `done` pulses once.
- `ARESETn` low mid-pass 1 (beat 5), released, then `start` reissued: all outputs 0 during reset; the new run begins at address 0 with `TUSER`=1 and `pass_idx`=0.
- NUM_PASSES=1, IMG_WIDTH=2, IMG_HEIGHT=1: 2 beats with `TUSER` on beat 0 and `TLAST` on beat 1; `done` in cycle 4.

Source files
------------

// File: rtl/axis_frame_source_if.sv
// rtl/axis_frame_source_if.sv - AXI4-Stream pixel beat bundle between frame source and haze-removal core
//
// Signals:
//   TDATA  [31:0] {8'd0, R, G, B}
//   TVALID        head beat present
//   TLAST         last pixel of a line
//   TUSER         first pixel of a pass
//   TREADY        sink accepts the beat
// Modports: master (frame source side), slave (sink side).
interface axis_frame_source_if;
    logic [31:0] TDATA;
    logic        TVALID;
    logic        TLAST;
    logic        TUSER;
    logic        TREADY;

    modport master (
        output TDATA,
        output TVALID,
        output TLAST,
        output TUSER,
        input  TREADY
    );

    modport slave (
        input  TDATA,
        input  TVALID,
        input  TLAST,
        input  TUSER,
        output TREADY
    );
endinterface

// File: rtl/axis_frame_source.sv
// rtl/axis_frame_source.sv - replays a stored RGB frame NUM_PASSES times as an AXI4-Stream
//
// Ports:
//   ACLK, ARESETn     clock, asynchronous active-low reset
//   start             one-cycle run request, honoured only when idle
//   busy              run in progress (reading or draining)
//   done              one-cycle pulse after the final beat handshake
//   pass_idx          pass currently being read, 0-based
//   mem_en, mem_addr  pixel memory read port, address = row*IMG_WIDTH+col
//   mem_rdata         {R,G,B}, valid the cycle after mem_en
//   M_AXIS            stream master (TDATA/TVALID/TLAST/TUSER/TREADY)
module axis_frame_source #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int ADDR_WIDTH = 18,
    parameter int NUM_PASSES = 2
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            pass_idx,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [23:0]           mem_rdata,
    axis_frame_source_if.master   M_AXIS
);
    localparam int                    COL_WIDTH = $clog2(IMG_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);
    localparam logic [COL_WIDTH-1:0]  LAST_COL  = COL_WIDTH'(IMG_WIDTH - 1);
    localparam logic [1:0]            LAST_PASS = 2'(NUM_PASSES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_WIDTH-1:0] addr;
    logic [COL_WIDTH-1:0]  col;

    // Sideband of the read currently in flight; its pixel arrives on mem_rdata.
    logic pend_valid;
    logic pend_first;
    logic pend_last;

    // Buffer entries are {first, last, rgb}; entry 0 is the head.
    logic [25:0] fifo_q [2];
    logic [1:0]  fifo_cnt;

    logic        head_valid;
    logic [25:0] head_word;
    logic        pop;
    logic        fifo_pop;
    logic        fifo_push;
    logic        wr_sel;
    logic [2:0]  occ;
    logic        issue;

    // When the buffer is empty the returning read is presented directly, so a
    // read issued in cycle n is a visible beat in cycle n+1 and a continuous
    // stream needs only one read in flight. A stalled in-flight beat drops into
    // the buffer unchanged, so the presented beat stays stable.
    always_comb begin
        head_valid = (fifo_cnt != 2'd0) || pend_valid;
        head_word  = (fifo_cnt != 2'd0) ? fifo_q[0] : {pend_first, pend_last, mem_rdata};
        pop        = head_valid && M_AXIS.TREADY;
        fifo_pop   = pop && (fifo_cnt != 2'd0);
        fifo_push  = pend_valid && !(pop && (fifo_cnt == 2'd0));
        wr_sel     = (fifo_cnt - {1'b0, fifo_pop}) != 2'd0;
        // Beats held after this cycle's pop: buffered plus in flight.
        occ        = {1'b0, fifo_cnt} + {2'b0, pend_valid} - {2'b0, pop};
        issue      = (state == S_RUN) && (occ < 3'd2);
    end

    assign M_AXIS.TVALID = head_valid;
    assign M_AXIS.TDATA  = head_valid ? {8'd0, head_word[23:0]} : 32'd0;
    assign M_AXIS.TLAST  = head_valid && head_word[24];
    assign M_AXIS.TUSER  = head_valid && head_word[25];

    assign mem_en   = issue;
    assign mem_addr = addr;
    assign busy     = (state == S_RUN) || (state == S_DRAIN);
    assign done     = (state == S_DONE);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (issue && (addr == LAST_ADDR) && (pass_idx == LAST_PASS)) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (occ == 3'd0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Read address, column and pass counters. A frame is whole lines, so the
    // column wraps together with the address at the end of each pass.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            addr     <= '0;
            col      <= '0;
            pass_idx <= 2'd0;
        end else if ((state == S_IDLE) && start) begin
            addr     <= '0;
            col      <= '0;
            pass_idx <= 2'd0;
        end else if (issue) begin
            if (addr == LAST_ADDR) begin
                addr <= '0;
                if (pass_idx != LAST_PASS) begin
                    pass_idx <= pass_idx + 2'd1;
                end
            end else begin
                addr <= addr + ADDR_WIDTH'(1);
            end
            col <= (col == LAST_COL) ? '0 : col + COL_WIDTH'(1);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            pend_valid <= 1'b0;
            pend_first <= 1'b0;
            pend_last  <= 1'b0;
        end else begin
            pend_valid <= issue;
            if (issue) begin
                pend_first <= (addr == '0);
                pend_last  <= (col == LAST_COL);
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            fifo_cnt  <= 2'd0;
        end else begin
            if (fifo_pop) begin
                fifo_q[0] <= fifo_q[1];
            end
            if (fifo_push) begin
                fifo_q[wr_sel] <= {pend_first, pend_last, mem_rdata};
            end
            fifo_cnt <= fifo_cnt + {1'b0, fifo_push} - {1'b0, fifo_pop};
        end
    end
endmodule

// File: tb/tb_axis_frame_source.sv
// tb/tb_axis_frame_source.sv - scoreboard bench for axis_frame_source (4x2x2 and 2x1x1 frames)
module tb_axis_frame_source;
    logic ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    logic ARESETn;

    logic        start_a, busy_a, done_a, mem_en_a;
    logic [1:0]  pass_a;
    logic [2:0]  addr_a;
    logic [23:0] rdata_a = 24'd0;

    logic        start_b, busy_b, done_b, mem_en_b;
    logic [1:0]  pass_b;
    logic [0:0]  addr_b;
    logic [23:0] rdata_b = 24'd0;

    axis_frame_source_if axa();
    axis_frame_source_if axb();

    axis_frame_source #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .ADDR_WIDTH(3), .NUM_PASSES(2)) dut_a (
        .ACLK(ACLK), .ARESETn(ARESETn), .start(start_a), .busy(busy_a), .done(done_a),
        .pass_idx(pass_a), .mem_en(mem_en_a), .mem_addr(addr_a), .mem_rdata(rdata_a), .M_AXIS(axa)
    );

    axis_frame_source #(.IMG_WIDTH(2), .IMG_HEIGHT(1), .ADDR_WIDTH(1), .NUM_PASSES(1)) dut_b (
        .ACLK(ACLK), .ARESETn(ARESETn), .start(start_b), .busy(busy_b), .done(done_b),
        .pass_idx(pass_b), .mem_en(mem_en_b), .mem_addr(addr_b), .mem_rdata(rdata_b), .M_AXIS(axb)
    );

    function automatic logic [23:0] pat(input int a);
        logic [7:0] b;
        b = a[7:0];
        return {b, ~b, b ^ 8'h5A};
    endfunction

    // Synchronous single-port pixel memory, one cycle read latency.
    always @(posedge ACLK) if (mem_en_a) rdata_a <= pat(int'(addr_a));
    always @(posedge ACLK) if (mem_en_b) rdata_b <= pat(int'(addr_b));

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    int pcyc = 0;
    always @(posedge ACLK) pcyc <= pcyc + 1;

    // Shared run context (driver writes, monitors read).
    int  mode = 0;
    int  t_base = 0;
    int  t_base_b = 0;
    int  exp_first = 0;
    int  beats = 0;
    int  done_cnt = 0;
    int  last_hs = 0;
    int  beats_b = 0;
    int  done_b_cnt = 0;
    bit  armed = 1'b0;
    logic [33:0] q_a[$];
    logic [33:0] q_b[$];

    // Monitor A
    int          rel_a, reads_a, hs_a, outs_a;
    logic        pop_a, prev_stall;
    logic [33:0] prev_word, got_a, exp_a;

    always @(negedge ACLK) begin
        if (!ARESETn) begin
            reads_a = 0;
            hs_a = 0;
            prev_stall = 1'b0;
        end else begin
            rel_a  = pcyc - t_base;
            pop_a  = axa.TVALID && axa.TREADY;
            outs_a = reads_a - hs_a;
            got_a  = {axa.TUSER, axa.TLAST, axa.TDATA};
            if (prev_stall) begin
                chk("stall_tvalid", axa.TVALID, 1);
                chk("stall_hold", got_a, prev_word);
            end
            if (armed && rel_a == 1) begin
                chk("c1_busy", busy_a, 1);
                chk("c1_mem_en", mem_en_a, 1);
                chk("c1_mem_addr", addr_a, 0);
                chk("c1_pass_idx", pass_a, 0);
            end
            if (mem_en_a)
                chk("mem_en_room", (outs_a - int'(pop_a)) < 2, 1);
            if (armed && mode == 2 && rel_a >= 3 && rel_a <= 10)
                chk("stall_mem_en", mem_en_a, 0);
            if (armed && mode == 2 && rel_a >= 4 && rel_a <= 10)
                chk("stall_buffered", outs_a, 2);
            if (pop_a) begin
                if (q_a.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    exp_a = q_a.pop_front();
                    chk("tdata", axa.TDATA, exp_a[31:0]);
                    chk("tlast", axa.TLAST, exp_a[32]);
                    chk("tuser", axa.TUSER, exp_a[33]);
                end
                if (exp_first > 0) chk("beat_cycle", rel_a, exp_first + beats);
                last_hs = rel_a;
                beats++;
            end
            if (done_a) begin
                chk("done_cycle", rel_a, last_hs + 1);
                chk("beats_at_done", beats, 16);
                chk("sb_empty_at_done", q_a.size(), 0);
                chk("busy_at_done", busy_a, 0);
                done_cnt++;
            end
            prev_stall = axa.TVALID && !axa.TREADY;
            prev_word  = got_a;
            reads_a   += int'(mem_en_a);
            hs_a      += int'(pop_a);
        end
    end

    // Monitor B
    int          rel_b;
    logic [33:0] exp_b;

    always @(negedge ACLK) begin
        if (ARESETn) begin
            rel_b = pcyc - t_base_b;
            if (axb.TVALID && axb.TREADY) begin
                if (q_b.size() == 0) begin
                    chk("b_extra_beat", 1, 0);
                end else begin
                    exp_b = q_b.pop_front();
                    chk("b_tdata", axb.TDATA, exp_b[31:0]);
                    chk("b_tlast", axb.TLAST, exp_b[32]);
                    chk("b_tuser", axb.TUSER, exp_b[33]);
                end
                chk("b_beat_cycle", rel_b, 2 + beats_b);
                beats_b++;
            end
            if (done_b) begin
                chk("b_done_cycle", rel_b, 4);
                done_b_cnt++;
            end
        end
    end

    // Modes: 0 full rate, 1 random TREADY, 2 TREADY low cycles 1..10,
    // 3 start pulsed while busy and on the done cycle, 4 reset after 5 beats.
    task automatic run_a(input int m);
        int rel;
        bit fin;
        int tail;
        mode = m;
        beats = 0;
        done_cnt = 0;
        last_hs = 0;
        exp_first = (m == 2) ? 11 : ((m == 1) ? 0 : 2);
        q_a.delete();
        for (int p = 0; p < 2; p++)
            for (int a = 0; a < 8; a++)
                q_a.push_back({a == 0, (a % 4) == 3, 8'd0, pat(a)});
        @(posedge ACLK); #1;
        t_base = pcyc;
        start_a = 1'b1;
        armed = 1'b1;
        @(posedge ACLK); #1;
        start_a = 1'b0;
        fin = 1'b0;
        tail = 0;
        for (int i = 0; i < 300 && !fin; i++) begin
            rel = pcyc - t_base;
            case (m)
                1:       axa.TREADY = 1'($urandom_range(0, 1));
                2:       axa.TREADY = !(rel >= 1 && rel <= 10);
                default: axa.TREADY = 1'b1;
            endcase
            if (m == 3) start_a = (rel == 5) || (rel == 18);
            if (m == 4 && beats >= 5) begin
                ARESETn = 1'b0;
                #1;
                chk("rst_tvalid", axa.TVALID, 0);
                chk("rst_tdata", axa.TDATA, 0);
                chk("rst_tlast", axa.TLAST, 0);
                chk("rst_tuser", axa.TUSER, 0);
                chk("rst_mem_en", mem_en_a, 0);
                chk("rst_mem_addr", addr_a, 0);
                chk("rst_busy", busy_a, 0);
                chk("rst_done", done_a, 0);
                chk("rst_pass_idx", pass_a, 0);
                q_a.delete();
                armed = 1'b0;
                repeat (3) @(posedge ACLK);
                #1 ARESETn = 1'b1;
                fin = 1'b1;
            end
            if (done_cnt > 0) begin
                tail++;
                if (tail > 3) fin = 1'b1;
            end
            if (!fin) begin
                @(posedge ACLK); #1;
            end
        end
        if (!fin) chk("run_timeout", 0, 1);
        if (m != 4) chk("done_pulses", done_cnt, 1);
        start_a = 1'b0;
        axa.TREADY = 1'b1;
    endtask

    task automatic run_b();
        int tail;
        q_b.delete();
        q_b.push_back({1'b1, 1'b0, 8'd0, pat(0)});
        q_b.push_back({1'b0, 1'b1, 8'd0, pat(1)});
        beats_b = 0;
        done_b_cnt = 0;
        @(posedge ACLK); #1;
        t_base_b = pcyc;
        start_b = 1'b1;
        @(posedge ACLK); #1;
        start_b = 1'b0;
        tail = 0;
        for (int i = 0; i < 50 && tail < 3; i++) begin
            if (done_b_cnt > 0) tail++;
            @(posedge ACLK); #1;
        end
        if (tail < 3) chk("b_run_timeout", 0, 1);
        chk("b_done_pulses", done_b_cnt, 1);
        chk("b_beats", beats_b, 2);
    endtask

    initial begin
        ARESETn = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        axa.TREADY = 1'b1;
        axb.TREADY = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        chk("reset_tvalid", axa.TVALID, 0);
        chk("reset_tdata", axa.TDATA, 0);
        chk("reset_mem_en", mem_en_a, 0);
        chk("reset_busy", busy_a, 0);
        chk("reset_done", done_a, 0);
        chk("reset_pass_idx", pass_a, 0);
        chk("reset_b_tvalid", axb.TVALID, 0);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        run_a(0);
        run_a(1);
        run_a(1);
        run_a(2);
        run_a(3);
        run_a(4);
        run_a(0);
        run_b();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
